handshake_sink_checker: RTL and testbench
=========================================

# handshake_sink_checker

Terminal consumer for a valid/ready data channel such as the output of a constant or dataflow unit. It accepts tokens, compares each against a compile-time expected value, counts accepted tokens, and latches the index and data of the first mismatch. It sits at the end of a dataflow graph, in place of a plain sink, for on-chip self-check.

## Interface
- DATA_WIDTH, 32, width of the `ins` data.
- EXPECTED, 0, value every accepted token must equal; only the low DATA_WIDTH bits are used.
- COUNT_WIDTH, 16, width of the token counter and of `bad_index`.
- TARGET_COUNT, 1, number of accepted tokens that raises `done`; legal range 1 to 2^COUNT_WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ins  input  DATA_WIDTH  token data.
- ins_valid  input  1  producer offers a token.
- ins_ready  output  1  sink can accept a token.
- count  output  COUNT_WIDTH  number of tokens accepted, saturating.
- done  output  1  count has reached TARGET_COUNT (sticky).
- error  output  1  at least one mismatch seen (sticky).
- bad_data  output  DATA_WIDTH  data of the first mismatching token.
- bad_index  output  COUNT_WIDTH  0-based index of the first mismatching token.

## Operation
- Handshake: a token transfers on a rising edge where `ins_valid && ins_ready`. `ins_ready` is derived from registered state only and never depends combinationally on `ins_valid` or `ins`.
- States:
  - INIT, entered on reset: `ins_ready`=0. Moves to RUN unconditionally on the next edge.
  - RUN: `ins_ready`=1 (subject to the stall feature). A transfer with `ins` != EXPECTED moves to ERROR and captures `bad_data`=`ins` and `bad_index`=`count` (the pre-increment value).
  - ERROR: terminal until reset. Keeps accepting tokens so the graph does not deadlock. `bad_data` and `bad_index` are frozen.
- Counter:
  - Every transfer increments `count` by 1.
  - At 2^COUNT_WIDTH-1 the counter holds; it never wraps.
  - Mismatching tokens are counted too.
- `done`: set on the edge where `count` becomes equal to TARGET_COUNT, then held until reset. Further tokens are still accepted after `done`.
- Reset values: `ins_ready`=0, `count`=0, `done`=0, `error`=0, `bad_data`=0, `bad_index`=0, state=INIT.
- Reset mid-stream: a token presented in the reset cycle is not accepted and not counted. All capture registers clear.

## Timing
- `ins_ready` first goes high in the second cycle after `rst` deasserts (one INIT cycle).
- `count`, `done`, `error`, `bad_data` and `bad_index` all reflect a transfer on the cycle after the transfer edge (1-cycle latency). All are registered outputs.
- Full throughput: one token per cycle in RUN and ERROR when the stall feature is off.
- When the TARGET_COUNT-th transfer is also the first mismatch, `done` and `error` rise in the same cycle.
- A token with `ins_valid` high while `ins_ready` is low is not consumed. The producer must hold it; the sink places no requirement on data stability.

## Configuration
- HANDSHAKE_SINK_CHECKER_STALL_EN:
  - Defined: a 2-bit free-running phase counter (reset 0, increments every cycle after reset) forces `ins_ready`=0 whenever phase==3 in RUN and ERROR. This gives deterministic backpressure, at most 3 transfers per 4 cycles.
  - Undefined: no phase counter; `ins_ready`=1 in RUN and ERROR.
- The macro changes only `ins_ready`. Counting, checking and capture rules are identical in both builds.

## Test plan
- Reset release with `ins_valid`=1: `ins_ready`=0 in the INIT cycle, 1 on the next cycle; `count`=0 until the first transfer.
- Stream 5 tokens of EXPECTED=0x2F7E7E7B, TARGET_COUNT=5, back-to-back: `count` steps 1..5, `done`=1 the cycle after the 5th transfer, `error`=0.
- Tokens EXPECTED, EXPECTED, 0x1234, 0x5678: `error`=1 after the 3rd transfer, `bad_data`=0x1234, `bad_index`=2; after the 4th transfer `count`=4 and the captures are unchanged.
- COUNT_WIDTH=4 with 20 tokens: `count` saturates at 15; `ins_ready` stays high.
- Assert `rst` for 1 cycle after 3 tokens and a mismatch: all outputs return to 0, INIT is re-entered, and the next stream counts from 0.
- STALL_EN build, `ins_valid` held high for 8 cycles after INIT: `ins_ready` pattern 1,1,1,0,1,1,1,0 (phase-aligned), exactly 6 transfers, `count`=6.

Source files
------------

// File: rtl/handshake_sink_checker.sv
// handshake_sink_checker
//
// Terminal consumer for a valid/ready channel. Every accepted token is compared
// against EXPECTED; accepted tokens are counted (saturating), `done` rises once
// TARGET_COUNT tokens have been accepted, and the data and index of the first
// mismatching token are latched. After a mismatch the sink keeps accepting
// tokens so the upstream graph never deadlocks.
//
// Optional feature macro: HANDSHAKE_SINK_CHECKER_STALL_EN
//   When defined, a 2-bit phase counter drops `ins_ready` on every fourth
//   active cycle (phase == 3), giving deterministic backpressure. Only
//   `ins_ready` is affected.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   ins        in   token data [DATA_WIDTH]
//   ins_valid  in   producer offers a token
//   ins_ready  out  sink accepts a token (registered)
//   count      out  accepted tokens, saturating [COUNT_WIDTH]
//   done       out  count reached TARGET_COUNT (sticky)
//   error      out  a mismatch was seen (sticky)
//   bad_data   out  data of first mismatching token [DATA_WIDTH]
//   bad_index  out  0-based index of first mismatching token [COUNT_WIDTH]

module handshake_sink_checker #(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]  EXPECTED     = '0,
  parameter int unsigned            COUNT_WIDTH  = 16,
  parameter int unsigned            TARGET_COUNT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   done,
  output logic                   error,
  output logic [DATA_WIDTH-1:0]  bad_data,
  output logic [COUNT_WIDTH-1:0] bad_index
);

  localparam logic [COUNT_WIDTH-1:0] CountMax  = '1;
  localparam logic [COUNT_WIDTH-1:0] TargetCnt = COUNT_WIDTH'(TARGET_COUNT);

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StError
  } state_e;

  state_e                 state_q;
  logic                   ready_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   done_q;
  logic                   error_q;
  logic [DATA_WIDTH-1:0]  bad_data_q;
  logic [COUNT_WIDTH-1:0] bad_index_q;
`ifdef HANDSHAKE_SINK_CHECKER_STALL_EN
  logic [1:0]             phase_q;
`endif

  logic                   xfer;
  logic                   mismatch;
  logic [COUNT_WIDTH-1:0] count_inc;

  always_comb begin
    xfer      = ins_valid & ready_q;
    mismatch  = (ins != EXPECTED);
    count_inc = count_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      ready_q     <= 1'b0;
      count_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      bad_data_q  <= '0;
      bad_index_q <= '0;
`ifdef HANDSHAKE_SINK_CHECKER_STALL_EN
      phase_q     <= 2'd0;
`endif
    end else begin
      if (xfer) begin
        if (count_q != CountMax) begin
          count_q <= count_inc;
        end
        // TargetCnt is never 0, so the wrapped count_inc at saturation cannot match.
        if (count_inc == TargetCnt) begin
          done_q <= 1'b1;
        end
      end

      unique case (state_q)
        StInit: begin
          state_q <= StRun;
          ready_q <= 1'b1;
        end
        StRun: begin
          if (xfer && mismatch) begin
            state_q     <= StError;
            error_q     <= 1'b1;
            bad_data_q  <= ins;
            bad_index_q <= count_q;
          end
        end
        StError: begin
          // Terminal until reset; captures stay frozen.
        end
        default: begin
          state_q <= StInit;
          ready_q <= 1'b0;
        end
      endcase

`ifdef HANDSHAKE_SINK_CHECKER_STALL_EN
      // Phase sits at 0 in the first active cycle; ready is registered one
      // cycle ahead, so drop it when the next phase will be 3.
      if (state_q != StInit) begin
        phase_q <= phase_q + 2'd1;
        ready_q <= (phase_q != 2'd2);
      end
`endif
    end
  end

  assign ins_ready = ready_q;
  assign count     = count_q;
  assign done      = done_q;
  assign error     = error_q;
  assign bad_data  = bad_data_q;
  assign bad_index = bad_index_q;

endmodule

// File: tb/tb_handshake_sink_checker.sv
// Bench for handshake_sink_checker: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// token-level model (total accepted, first bad index/data, cycles since reset).

module tb_handshake_sink_checker;

  localparam int unsigned     DW    = 32;
  localparam int unsigned     CW    = 4;
  localparam int unsigned     TGT   = 5;
  localparam logic [DW-1:0]   EXP   = 32'h2F7E7E7B;
  localparam int unsigned     CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ins;
  logic          ins_valid;
  logic          ins_ready;
  logic [CW-1:0] count;
  logic          done;
  logic          error;
  logic [DW-1:0] bad_data;
  logic [CW-1:0] bad_index;

  int checks = 0;
  int errors = 0;

  handshake_sink_checker #(
    .DATA_WIDTH  (DW),
    .EXPECTED    (EXP),
    .COUNT_WIDTH (CW),
    .TARGET_COUNT(TGT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .count     (count),
    .done      (done),
    .error     (error),
    .bad_data  (bad_data),
    .bad_index (bad_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid = 1'b0;
  int unsigned m_cyc;      // cycles since the reset edge (0 = INIT cycle)
  int unsigned m_total;    // tokens accepted since reset, unbounded
  int          m_bad_idx;  // -1 until a mismatch is seen
  logic [DW-1:0] m_bad_data;

  function automatic bit model_ready();
    if (!m_valid || m_cyc == 0) return 1'b0;
`ifdef HANDSHAKE_SINK_CHECKER_STALL_EN
    return ((m_cyc - 1) % 4) != 3;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid    = 1'b1;
      m_cyc      = 0;
      m_total    = 0;
      m_bad_idx  = -1;
      m_bad_data = '0;
    end else if (m_valid) begin
      if (ins_valid && model_ready()) begin
        if (ins != EXP && m_bad_idx < 0) begin
          m_bad_idx  = (m_total > CMAX) ? CMAX : m_total;
          m_bad_data = ins;
        end
        m_total++;
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ins_ready", 32'(ins_ready), 32'(model_ready()));
      chk("count", 32'(count), (m_total > CMAX) ? CMAX : m_total);
      chk("done", 32'(done), 32'(m_total >= TGT));
      chk("error", 32'(error), 32'(m_bad_idx >= 0));
      chk("bad_data", bad_data, (m_bad_idx >= 0) ? m_bad_data : 32'd0);
      chk("bad_index", 32'(bad_index), (m_bad_idx >= 0) ? 32'(m_bad_idx) : 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    ins       = d;
    ins_valid = 1'b1;
    tick();
  endtask

`ifdef HANDSHAKE_SINK_CHECKER_STALL_EN
  bit pat [8];
`endif

  initial begin
    rst       = 1'b1;
    ins       = EXP;
    ins_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // INIT cycle: valid held high but nothing accepted.
    chk("init_ready", 32'(ins_ready), 32'd0);
    chk("init_count", 32'(count), 32'd0);
    tick();
    chk("run_ready", 32'(ins_ready), 32'd1);
    chk("run_count", 32'(count), 32'd0);

`ifdef HANDSHAKE_SINK_CHECKER_STALL_EN
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      chk("stall_pattern", 32'(ins_ready), 32'(pat[i]));
      tick();
    end
    chk("stall_count", 32'(count), 32'd6);
`else
    // Five matching tokens back-to-back.
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("stream_count", 32'(count), 32'(i));
      chk("stream_done", 32'(done), 32'(i == 5));
    end
    chk("stream_error", 32'(error), 32'd0);
    ins_valid = 1'b0;
    tick();

    // Fresh stream with a mismatch at index 2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ins_valid = 1'b0;
    tick();
    send(EXP);
    send(EXP);
    send(32'h1234);
    chk("mm_error", 32'(error), 32'd1);
    chk("mm_bad_data", bad_data, 32'h1234);
    chk("mm_bad_index", 32'(bad_index), 32'd2);
    send(32'h5678);
    chk("mm_count", 32'(count), 32'd4);
    chk("mm_bad_data_frozen", bad_data, 32'h1234);
    chk("mm_bad_index_frozen", 32'(bad_index), 32'd2);

    // Reset with a token offered: everything clears, nothing counted.
    ins = EXP;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_bad_data", bad_data, 32'd0);
    chk("rst_bad_index", 32'(bad_index), 32'd0);
    chk("rst_ready", 32'(ins_ready), 32'd0);
    tick();
    chk("rst_count_init", 32'(count), 32'd0);
    tick();
    chk("rst_restart_count", 32'(count), 32'd1);

    // 20 more tokens: the 4-bit counter must hold at 15.
    for (int i = 0; i < 20; i++) tick();
    chk("sat_count", 32'(count), 32'd15);
    chk("sat_ready", 32'(ins_ready), 32'd1);
    chk("sat_done", 32'(done), 32'd1);
`endif

    // Randomized traffic with occasional resets and mismatches.
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(99) == 0);
      ins_valid = ($urandom_range(9) < 7);
      ins       = ($urandom_range(19) == 0) ? DW'($urandom) : EXP;
      tick();
    end
    rst       = 1'b0;
    ins_valid = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
